// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite slave terminating the bus onto a bank of REG_COUNT 32-bit registers.
// The shared AXI4-Lite types are declared first so the file compiles on its own.
package axi4_lite_pkg;
    typedef enum logic [1:0] {
        RESPONSE_OKAY   = 2'b00,
        RESPONSE_EXOKAY = 2'b01,
        RESPONSE_SLVERR = 2'b10,
        RESPONSE_DECERR = 2'b11
    } response_t;

    typedef enum logic {
        PRIVILEGE_ACCESS_UNPRIVILEGED = 1'b0,
        PRIVILEGE_ACCESS_PRIVILEGED   = 1'b1
    } privilege_access_t;

    typedef enum logic {
        SECURITY_ACCESS_SECURE    = 1'b0,
        SECURITY_ACCESS_NONSECURE = 1'b1
    } security_access_t;

    typedef enum logic {
        TYPE_ACCESS_DATA        = 1'b0,
        TYPE_ACCESS_INSTRUCTION = 1'b1
    } type_access_t;

    // Field order matches AxPROT[2:0]: instruction, non-secure, privileged.
    typedef struct packed {
        type_access_t      type_access;
        security_access_t  security_access;
        privilege_access_t privilege_access;
    } access_t;
endpackage

module axi4_lite_reg_slave
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 16,
    parameter logic [REG_COUNT-1:0] PRIV_MASK = '0
) (
    input  logic                            aclk,
    input  logic                            areset_n,
    input  logic                            awvalid,
    output logic                            awready,
    input  logic [ADDR_WIDTH-1:0]           awaddr,
    input  access_t                         awprot,
    input  logic                            wvalid,
    output logic                            wready,
    input  logic [DATA_WIDTH-1:0]           wdata,
    input  logic [DATA_WIDTH/8-1:0]         wstrb,
    output logic                            bvalid,
    input  logic                            bready,
    output response_t                       bresp,
    input  logic                            arvalid,
    output logic                            arready,
    input  logic [ADDR_WIDTH-1:0]           araddr,
    input  access_t                         arprot,
    output logic                            rvalid,
    input  logic                            rready,
    output logic [DATA_WIDTH-1:0]           rdata,
    output response_t                       rresp,
    output logic [REG_COUNT*DATA_WIDTH-1:0] reg_q,
    output logic [REG_COUNT-1:0]            reg_wr,
    output logic [3:0]                      dbg_state
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = ADDR_WIDTH - 2;
    localparam int SEL_W  = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    w_state_t w_state_q, w_state_d;
    r_state_t r_state_q, r_state_d;

    logic                  aw_held, w_held;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic                  aw_priv_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]     w_strb_q;
    logic [DATA_WIDTH-1:0] regs [REG_COUNT];

    logic      aw_fire, w_fire, commit, ar_fire;
    response_t wr_resp, rd_resp;
    logic [SEL_W-1:0] wr_sel, rd_sel;
    logic      unused_prot;

    function automatic response_t decode(input logic [ADDR_WIDTH-1:0] addr, input logic priv);
        logic [IDX_W:0] idx;
        idx = {1'b0, addr[ADDR_WIDTH-1:2]};
        if (idx >= (IDX_W+1)'(REG_COUNT)) return RESPONSE_DECERR;
        if (addr[1:0] != 2'b00) return RESPONSE_SLVERR;
        if (PRIV_MASK[idx[SEL_W-1:0]] && !priv) return RESPONSE_SLVERR;
        return RESPONSE_OKAY;
    endfunction

    // Handshake: each channel transfers on a rising edge where valid && ready are both high;
    // once this slave raises bvalid/rvalid, the payload stays stable until that edge.
    assign awready = (w_state_q == W_IDLE) && !aw_held;
    assign wready  = (w_state_q == W_IDLE) && !w_held;
    assign arready = (r_state_q == R_IDLE);
    assign bvalid  = (w_state_q == W_RESP);
    assign rvalid  = (r_state_q == R_RESP);

    assign aw_fire = awvalid && awready;
    assign w_fire  = wvalid && wready;
    assign ar_fire = arvalid && arready;
    assign commit  = (w_state_q == W_IDLE) && aw_held && w_held;

    assign wr_resp = decode(aw_addr_q, aw_priv_q);
    assign rd_resp = decode(araddr, arprot.privilege_access == PRIVILEGE_ACCESS_PRIVILEGED);
    assign wr_sel  = aw_addr_q[SEL_W+1:2];
    assign rd_sel  = araddr[SEL_W+1:2];

    // Only the privilege bit of AxPROT influences decode.
    assign unused_prot = ^{awprot, arprot};

    assign dbg_state = {w_state_q == W_RESP, aw_held, w_held, r_state_q == R_RESP};

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (commit) w_state_d = W_RESP;
            W_RESP:  if (bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ar_fire) r_state_d = R_RESP;
            R_RESP:  if (rready) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // AW and W arrive in any order; each is parked until both are present.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            aw_priv_q <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            if (aw_fire) begin
                aw_held   <= 1'b1;
                aw_addr_q <= awaddr;
                aw_priv_q <= (awprot.privilege_access == PRIVILEGE_ACCESS_PRIVILEGED);
            end else if (commit) begin
                aw_held <= 1'b0;
            end
            if (w_fire) begin
                w_held   <= 1'b1;
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end else if (commit) begin
                w_held <= 1'b0;
            end
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
            reg_wr <= '0;
            bresp  <= RESPONSE_OKAY;
        end else begin
            if (commit) bresp <= wr_resp;
            for (int i = 0; i < REG_COUNT; i++) begin
                reg_wr[i] <= 1'b0;
                if (commit && wr_resp == RESPONSE_OKAY && wr_sel == SEL_W'(i)) begin
                    reg_wr[i] <= 1'b1;
                    for (int j = 0; j < STRB_W; j++) begin
                        if (w_strb_q[j]) regs[i][j*8 +: 8] <= w_data_q[j*8 +: 8];
                    end
                end
            end
        end
    end

    // Nonblocking update means a read accepted on a commit edge returns the old value.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            rdata <= '0;
            rresp <= RESPONSE_OKAY;
        end else if (ar_fire) begin
            rresp <= rd_resp;
            rdata <= (rd_resp == RESPONSE_OKAY) ? regs[rd_sel] : '0;
        end
    end

    for (genvar g = 0; g < REG_COUNT; g++) begin : g_reg_q
        assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end
endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Directed plus randomized bench for axi4_lite_reg_slave against an array-based
// register model; inputs change and outputs are sampled on the falling edge.
module tb_axi4_lite_reg_slave;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int RC = 16;
    localparam logic [RC-1:0] PMASK = 16'h0008;

    // ---------------- clock / reset ----------------
    logic aclk = 1'b0;
    logic areset_n = 1'b0;
    always #5 aclk = ~aclk;

    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic [DW-1:0] wdata, rdata;
    logic [3:0]    wstrb, dbg_state;
    logic [1:0]    bresp, rresp;
    logic [RC*DW-1:0] reg_q;
    logic [RC-1:0] reg_wr;

    axi4_lite_reg_slave #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_COUNT(RC), .PRIV_MASK(PMASK)
    ) dut (
        .aclk(aclk), .areset_n(areset_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .reg_q(reg_q), .reg_wr(reg_wr), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard / model ----------------
    int checks = 0;
    int errors = 0;
    logic [DW-1:0] model_regs [RC];
    logic [1:0]    exp_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Response from the address map: 16 words, word-aligned only, word 3 privileged.
    function automatic logic [1:0] model_resp(input logic [AW-1:0] addr, input logic [2:0] prot);
        int unsigned idx = int'(addr) / 4;
        if (idx >= RC) return 2'b11;
        if (int'(addr) % 4 != 0) return 2'b10;
        if (PMASK[idx] && prot[0] == 1'b0) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] strb);
        logic [31:0] m = 32'h0;
        for (int j = 0; j < 4; j++) if (strb[j]) m = m | (32'hFF << (8 * j));
        return m;
    endfunction

    function automatic void model_write(input logic [AW-1:0] addr, input logic [31:0] data,
                                        input logic [3:0] strb, input logic [2:0] prot);
        int unsigned idx = int'(addr) / 4;
        logic [31:0] m = lane_mask(strb);
        if (model_resp(addr, prot) == 2'b00)
            model_regs[idx] = (model_regs[idx] & ~m) | (data & m);
    endfunction

    task automatic check_regs(input string tag);
        for (int i = 0; i < RC; i++)
            check($sformatf("%s_reg%0d", tag, i), reg_q[i*DW +: DW], model_regs[i]);
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [2:0] prot, input int aw_dly, input int w_dly, input int b_dly);
        bit aw_done = 0, w_done = 0, aw_pend = 0, w_pend = 0;
        int cyc = 0;
        logic [1:0]  exp_resp = model_resp(addr, prot);
        logic [15:0] exp_wr = (exp_resp == 2'b00) ? (16'h1 << (int'(addr) / 4)) : 16'h0;
        exp_q.push_back(exp_resp);
        while (!(aw_done && w_done) && cyc < 50) begin
            @(negedge aclk);
            if (aw_pend) begin awvalid = 1'b0; aw_done = 1; aw_pend = 0; end
            if (w_pend)  begin wvalid  = 1'b0; w_done  = 1; w_pend  = 0; end
            if (w_done && !aw_done) check("wready_low_while_held", wready, 1'b0);
            if (aw_done && !w_done) check("awready_low_while_held", awready, 1'b0);
            if (!aw_done && cyc >= aw_dly) begin awvalid = 1'b1; awaddr = addr; awprot = prot; end
            if (!w_done && cyc >= w_dly) begin wvalid = 1'b1; wdata = data; wstrb = strb; end
            aw_pend = awvalid && awready;
            w_pend  = wvalid && wready;
            cyc++;
        end
        check("aw_w_accept_timeout", aw_done && w_done, 1'b1);
        check("bvalid_before_commit", bvalid, 1'b0);
        @(negedge aclk);
        check("bvalid_latency", bvalid, 1'b1);
        check("bresp", bresp, exp_q.pop_front());
        check("reg_wr_pulse", reg_wr, exp_wr);
        model_write(addr, data, strb, prot);
        check_regs("wr");
        for (int i = 0; i < b_dly; i++) begin
            @(negedge aclk);
            check("bvalid_hold", bvalid, 1'b1);
            check("bresp_hold", bresp, exp_resp);
            check("awready_in_resp", awready, 1'b0);
            check("wready_in_resp", wready, 1'b0);
            check("reg_wr_one_cycle", reg_wr, 16'h0);
        end
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        check("bvalid_after_hs", bvalid, 1'b0);
        check("reg_wr_clear", reg_wr, 16'h0);
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input logic [2:0] prot, input int r_dly);
        logic [1:0]  exp_resp = model_resp(addr, prot);
        logic [31:0] exp_data = (exp_resp == 2'b00) ? model_regs[int'(addr) / 4] : 32'h0;
        @(negedge aclk);
        check("arready_idle", arready, 1'b1);
        arvalid = 1'b1; araddr = addr; arprot = prot;
        @(negedge aclk);
        arvalid = 1'b0;
        check("rvalid", rvalid, 1'b1);
        check("rresp", rresp, exp_resp);
        check("rdata", rdata, exp_data);
        for (int i = 0; i < r_dly; i++) begin
            @(negedge aclk);
            check("rvalid_hold", rvalid, 1'b1);
            check("rdata_hold", rdata, exp_data);
            check("arready_in_resp", arready, 1'b0);
        end
        rready = 1'b1;
        @(negedge aclk);
        rready = 1'b0;
        check("rvalid_after_hs", rvalid, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [AW-1:0] a;
        logic [2:0]    p;
        logic [31:0]   old;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
        for (int i = 0; i < RC; i++) model_regs[i] = 32'h0;

        repeat (2) @(negedge aclk);
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_reg_wr", reg_wr, 16'h0);
        check("rst_bresp", bresp, 2'b00);
        check("rst_rresp", rresp, 2'b00);
        check("rst_rdata", rdata, 32'h0);
        check("rst_regq_zero", |reg_q, 1'b0);
        check("rst_awready", awready, 1'b1);
        check("rst_wready", wready, 1'b1);
        check("rst_arready", arready, 1'b1);
        areset_n = 1'b1;

        do_write(12'h004, 32'hDEADBEEF, 4'hF, 3'b000, 0, 0, 0);
        check("reg1_value", reg_q[1*DW +: DW], 32'hDEADBEEF);

        do_write(12'h008, 32'hFFFFFFFF, 4'hF, 3'b000, 0, 0, 0);
        do_write(12'h008, 32'h12345678, 4'h3, 3'b000, 2, 0, 0);
        check("reg2_partial", reg_q[2*DW +: DW], 32'hFFFF5678);

        do_write(12'h040, 32'h11111111, 4'hF, 3'b000, 0, 0, 0);
        do_read(12'h040, 3'b000, 0);
        do_write(12'h006, 32'h22222222, 4'hF, 3'b000, 1, 0, 0);
        do_read(12'h006, 3'b000, 0);

        do_write(12'h00C, 32'hA5A5A5A5, 4'hF, 3'b000, 0, 0, 0);
        check("priv_reg3_unchanged", reg_q[3*DW +: DW], 32'h0);
        do_write(12'h00C, 32'hA5A5A5A5, 4'hF, 3'b001, 0, 0, 0);
        check("priv_reg3_written", reg_q[3*DW +: DW], 32'hA5A5A5A5);
        do_read(12'h00C, 3'b000, 1);
        do_read(12'h00C, 3'b001, 0);

        do_write(12'h010, 32'h0BADF00D, 4'hF, 3'b000, 0, 0, 5);
        do_write(12'h010, 32'hFFFFFFFF, 4'h0, 3'b000, 0, 0, 0);

        // Read of word 1 accepted on the same edge that commits a new value to it.
        @(negedge aclk);
        old = model_regs[1];
        awvalid = 1; awaddr = 12'h004; awprot = 3'b000;
        wvalid = 1; wdata = 32'hCAFEF00D; wstrb = 4'hF;
        @(negedge aclk);
        awvalid = 0; wvalid = 0;
        check("coll_bvalid_early", bvalid, 1'b0);
        check("coll_arready", arready, 1'b1);
        arvalid = 1; araddr = 12'h004; arprot = 3'b000;
        @(negedge aclk);
        arvalid = 0;
        check("coll_rvalid", rvalid, 1'b1);
        check("coll_rdata_old", rdata, old);
        check("coll_bvalid", bvalid, 1'b1);
        check("coll_bresp", bresp, 2'b00);
        check("coll_reg_wr", reg_wr, 16'h0002);
        model_write(12'h004, 32'hCAFEF00D, 4'hF, 3'b000);
        check("coll_reg1_new", reg_q[1*DW +: DW], 32'hCAFEF00D);
        bready = 1; rready = 1;
        @(negedge aclk);
        bready = 0; rready = 0;
        check("coll_bvalid_done", bvalid, 1'b0);
        check("coll_rvalid_done", rvalid, 1'b0);

        for (int n = 0; n < 40; n++) begin
            a = AW'($urandom_range(0, 12'h04F));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            p = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom_range(0, 15)), p,
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            else
                do_read(a, p, $urandom_range(0, 2));
        end

        // Reset while both a write response and a read response are pending.
        @(negedge aclk);
        awvalid = 1; awaddr = 12'h014; awprot = 3'b000;
        wvalid = 1; wdata = 32'h55AA55AA; wstrb = 4'hF;
        arvalid = 1; araddr = 12'h004; arprot = 3'b000;
        @(negedge aclk);
        awvalid = 0; wvalid = 0; arvalid = 0;
        check("prerst_rvalid", rvalid, 1'b1);
        @(negedge aclk);
        check("prerst_bvalid", bvalid, 1'b1);
        #2 areset_n = 1'b0;
        #1;
        check("midrst_bvalid", bvalid, 1'b0);
        check("midrst_rvalid", rvalid, 1'b0);
        check("midrst_regq_zero", |reg_q, 1'b0);
        check("midrst_reg_wr", reg_wr, 16'h0);
        check("midrst_awready", awready, 1'b1);
        @(negedge aclk);
        areset_n = 1'b1;
        for (int i = 0; i < RC; i++) model_regs[i] = 32'h0;
        repeat (3) begin
            @(negedge aclk);
            check("postrst_bvalid", bvalid, 1'b0);
            check("postrst_rvalid", rvalid, 1'b0);
        end
        do_write(12'h004, 32'h00000001, 4'hF, 3'b000, 0, 0, 0);
        do_read(12'h004, 3'b000, 0);

        check("scoreboard_drained", exp_q.size(), 0);

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi4_lite_reg_slave.md
Name: axi4_lite_reg_slave

Overview:
AXI4-Lite slave endpoint that terminates the bus and exposes a bank of REG_COUNT control/status registers to local logic. It uses the team's axi4_lite_pkg types: access_t for AxPROT and response_t for BRESP/RRESP. It sits directly downstream of the interconnect and is the first consumer of those types. Independent write and read channels; one outstanding transaction per direction.

Parameters:
ADDR_WIDTH, 12, byte address width of awaddr/araddr
DATA_WIDTH, 32, data width; only 32 supported (4 byte lanes)
REG_COUNT, 16, number of registers; word index = addr[ADDR_WIDTH-1:2]
PRIV_MASK, '0, REG_COUNT bits; bit i set -> register i requires PRIVILEGE_ACCESS_PRIVILEGED

Ports:
aclk  input  1  clock, all logic rising-edge
areset_n  input  1  asynchronous active-low reset
awvalid/awready  input/output  1/1  write address handshake
awaddr  input  ADDR_WIDTH  write byte address
awprot  input  access_t(3)  write access attributes
wvalid/wready  input/output  1/1  write data handshake
wdata  input  DATA_WIDTH  write data
wstrb  input  DATA_WIDTH/8  byte-lane enables
bvalid/bready  output/input  1/1  write response handshake
bresp  output  response_t(2)  write response
arvalid/arready  input/output  1/1  read address handshake
araddr  input  ADDR_WIDTH  read byte address
arprot  input  access_t(3)  read access attributes
rvalid/rready  output/input  1/1  read data handshake
rdata  output  DATA_WIDTH  read data
rresp  output  response_t(2)  read response
reg_q  output  REG_COUNT*DATA_WIDTH  register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
reg_wr  output  REG_COUNT  one-cycle pulse, bit i set the cycle after register i is updated

Behaviour:
- Reset (areset_n low, async): all registers 0, bvalid/rvalid/reg_wr 0, bresp/rresp RESPONSE_OKAY, rdata 0, holding flags clear. awready/wready/arready are then 1.
- Write path states: W_IDLE, W_RESP. In W_IDLE, AW and W are captured independently into holding registers. awready = !aw_held. wready = !w_held. Both readies are 0 in W_RESP.
- When both are held (including same-cycle capture at edge k): decode and commit at edge k+1, bvalid=1 from k+1, state W_RESP. Holding flags clear at commit.
- W_RESP: bvalid held with stable bresp until bready; on the handshake edge return to W_IDLE. The next AW/W can be accepted on the following cycle.
- Write decode, priority order:
  - index >= REG_COUNT -> RESPONSE_DECERR
  - awaddr[1:0] != 0 -> RESPONSE_SLVERR
  - PRIV_MASK[index] set and awprot.privilege_access == UNPRIVILEGED -> RESPONSE_SLVERR
  - otherwise RESPONSE_OKAY
- Registers update only on OKAY, byte lane j only if wstrb[j]. Errors leave registers unchanged and raise no reg_wr.
- reg_wr[i] pulses for one cycle after an OKAY commit, including when wstrb == 0 (register value unchanged).
- Read path states: R_IDLE, R_RESP. arready = (state == R_IDLE). Accept at edge k -> rvalid=1 from k, rdata/rresp registered; data is the register value before any write committed at the same edge.
- Read decode follows the same priority as writes, using arprot. On error, rdata = 0.
- rvalid/rdata/rresp stay stable until rready, then return to R_IDLE; back-to-back reads give one transfer per 2 cycles.
- The read and write paths are fully independent; simultaneous activity is legal.
- Reset asserted mid-transaction aborts everything immediately. No response is issued after reset deasserts.
- awprot.security_access and type_access are ignored.

Test Plan:
- Reset, then AW+W same cycle: addr 0x004, wdata 0xDEADBEEF, wstrb 0xF -> bvalid next cycle, bresp OKAY, reg_q[1] = 0xDEADBEEF, reg_wr = 0x0002 for one cycle.
- W 2 cycles before AW: addr 0x008, wstrb 0x3, wdata 0x12345678 over reg 2 = 0xFFFFFFFF -> wready low while waiting, final reg 2 = 0xFFFF5678, OKAY.
- Addr 0x040 with REG_COUNT=16 -> DECERR on both write and read, rdata 0, no reg change. Addr 0x006 -> SLVERR.
- PRIV_MASK bit 3 set, awprot 3'b000 write to 0x00C -> SLVERR, reg unchanged. Repeat with awprot 3'b001 -> OKAY.
- Hold bready low 5 cycles -> bvalid/bresp stable, awready/wready 0. Read 0x004 at the same edge as a write commit to 0x004 -> old value returned.
- Assert areset_n low while bvalid pending -> bvalid 0 immediately, all registers 0.
